sseg_display_arbiter: RTL
=========================

# sseg_display_arbiter

Shares the board's 4-digit seven-segment display between two requesting datapaths, such as the adder result and the raw switch view. A round-robin arbiter grants the display to one source and holds the grant for a minimum dwell time. A scan sequencer time-division multiplexes the granted 16-bit hex value across the four digits, with optional leading-zero blanking. It replaces the fixed two-digit wiring at the top level, and its outputs drive the board's `an`/`sseg` pins directly.

## Interface
- `REFRESH_BITS`, default 18: width of the free-running scan counter; each digit slot lasts 2^(REFRESH_BITS-2) cycles.
- `DWELL_CYCLES`, default 50_000_000: minimum number of cycles a grant is held; at least 2.
- `DWELL_W`, default 26: width of the dwell counter; must satisfy 2^DWELL_W ≥ DWELL_CYCLES.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  2  request lines; `req[i]` high means source i wants the display.
- `val0`, `val1`  in  16 each  hex value of source 0 and source 1; `[3:0]` goes to digit 0 (rightmost).
- `dp0`, `dp1`  in  4 each  per-digit decimal point for each source, active-high.
- `blank_lz`  in  1  enables leading-zero blanking.
- `gnt`  out  2  one-hot grant, or 00 when idle; registered.
- `an`  out  4  digit enables, active-low; registered.
- `sseg`  out  8  segments, active-low; bit 7 = dp, bits 6:0 = {g,f,e,d,c,b,a}; registered.

## Operation
- **Arbiter FSM states:** IDLE, HOLD0, HOLD1. A round-robin pointer `rr` names the source that wins a tie.
- **IDLE:**
  - `gnt`=00; the display is blank (`an`=1111, `sseg`=8'hFF).
  - If only one `req` bit is set, go to that source's HOLD state.
  - If both are set, go to HOLD`rr`.
- **Entering HOLDx:** `gnt` becomes one-hot x, the dwell counter clears to 0, and `rr` becomes the other source.
- **During HOLDx:**
  - The dwell counter increments every cycle.
  - The grant is held unconditionally while the counter is below DWELL_CYCLES-1; dropping `req` mid-dwell does not release it.
- **At dwell expiry (counter == DWELL_CYCLES-1):**
  - If the other source is requesting, switch to the other HOLD state; the counter clears.
  - Otherwise, if source x is still requesting, stay in HOLDx; the counter clears and the grant is re-armed.
  - Otherwise, go to IDLE.
- **Value selection:**
  - The granted source's `val`/`dp` is muxed live every cycle; values are not latched at grant time.
- **Scan:**
  - The REFRESH_BITS counter runs freely in all states.
  - The digit index k is the counter's top two bits.
  - Nibble k of the selected value is decoded to hex segments.
  - `sseg[7]` = ~dp[k].
  - `an` is one-hot-low at position k.
- **Hex decode, {g..a}:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- **Leading-zero blanking:**
  - With `blank_lz`=1, digit k (k=3..1) is blanked when nibble k and every higher nibble are zero.
  - Digit 0 is never blanked.
  - A blanked slot drives `an`=1111 and `sseg`=8'hFF.
- **Width rules:** the dwell counter never exceeds DWELL_CYCLES-1; the scan counter wraps modulo 2^REFRESH_BITS.

## Timing
- **Reset values, asserted asynchronously while `reset`=0 with no clock edge required:**
  - state IDLE, `rr`=0
  - counters 0
  - `gnt`=00, `an`=1111, `sseg`=8'hFF
- **Grant latency:** `req` is sampled on a rising edge; `gnt` rises on that same edge when leaving IDLE, so it is visible one cycle after `req` is presented.
- **Grant length:** each grant lasts exactly DWELL_CYCLES cycles before any change (switch, re-arm or release).
- **Display latency:** `an`/`sseg` are registered from the current state, digit index and value, so they reflect a change of grant, digit or value one cycle later.
- **Release to IDLE:** blank display one cycle after `gnt` goes to 00.
- **Simultaneous events:**
  - Both requests rising in IDLE: `rr` decides.
  - A request arriving exactly at expiry is honoured on that edge.
- **Reset mid-grant:** aborts immediately; after release the FSM resumes from IDLE with `rr`=0.

## Test plan
Use REFRESH_BITS=4 (4-cycle digit slots) and DWELL_CYCLES=8.
1. Hold `reset`=0 and toggle `req`=11 → `gnt`=00, `an`=1111, `sseg`=FF throughout. Release with `req`=00 → outputs unchanged for 32 cycles.
2. `req`=01, `val0`=16'h1234, `dp0`=0, `blank_lz`=0 →
   - `gnt`=01 one cycle later.
   - Over 16 cycles the display shows `an`/`sseg` pairs 1110/99, 1101/B0, 1011/A4, 0111/F9, each for 4 cycles.
3. `req`=11 from IDLE after reset →
   - `gnt` reads 01 for exactly 8 cycles, then 10 for 8, then 01 again.
   - `sseg` follows `val1` one cycle after each switch.
4. `val0`=16'h0005, `dp0`=4'b0001, `blank_lz`=1 →
   - Only the digit-0 slot is lit, with `an`=1110 and `sseg`=8'h12.
   - The other three slots show `an`=1111.
   - With `blank_lz`=0, the digit 1–3 slots show `sseg`=C0.
5. `req`=01 with `req[0]` dropped on the 3rd grant cycle →
   - `gnt` stays 01 until 8 cycles have elapsed, then goes to 00.
   - `an`=1111 one cycle later.
6. Assert `reset`=0 asynchronously, between clock edges, mid-HOLD1 → `gnt`=00, `an`=1111, `sseg`=FF immediately. After release with `req`=11 → source 0 is granted first.

Source files
------------

// File: rtl/sseg_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_display_arbiter
//  Description : Round-robin arbiter with minimum dwell that shares a 4-digit
//                seven-segment display between two 16-bit hex sources, plus
//                a free-running scan sequencer with leading-zero blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_display_arbiter #(
    parameter int REFRESH_BITS = 18,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int DWELL_W      = 26
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active-low
    input  logic [1:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [3:0]  dp0,
    input  logic [3:0]  dp1,
    input  logic        blank_lz,
    output logic [1:0]  gnt,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD0 = 2'd1,
        S_HOLD1 = 2'd2
    } state_t;

    // Last dwell count of a grant; the decision to switch/re-arm/release is
    // taken on the edge where the counter sits at this value.
    localparam logic [DWELL_W-1:0] c_DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t                   r_state;
    logic                     r_rr;
    logic [DWELL_W-1:0]       r_dwell;
    logic [1:0]               r_gnt;
    logic [REFRESH_BITS-1:0]  r_scan;
    logic [3:0]               r_an;
    logic [7:0]               r_sseg;

    logic [1:0]               w_digit;
    logic [15:0]              w_val;
    logic [3:0]               w_dp;
    logic [3:0]               w_nibble;
    logic                     w_lz_zero;
    logic                     w_blank;
    logic [6:0]               w_hex;
    logic [3:0]               w_an_next;
    logic [7:0]               w_sseg_next;

    // Arbiter FSM: grant selection, dwell timing and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_dwell <= '0;
            r_gnt   <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req[0] && (!req[1] || !r_rr)) begin
                        r_state <= S_HOLD0;
                        r_gnt   <= 2'b01;
                        r_dwell <= '0;
                        r_rr    <= 1'b1;
                    end else if (req[1]) begin
                        r_state <= S_HOLD1;
                        r_gnt   <= 2'b10;
                        r_dwell <= '0;
                        r_rr    <= 1'b0;
                    end
                end
                S_HOLD0: begin
                    if (r_dwell != c_DWELL_LAST) begin
                        r_dwell <= r_dwell + DWELL_W'(1);
                    end else if (req[1]) begin
                        r_state <= S_HOLD1;
                        r_gnt   <= 2'b10;
                        r_dwell <= '0;
                        r_rr    <= 1'b0;
                    end else if (req[0]) begin
                        r_dwell <= '0;
                        r_rr    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_gnt   <= 2'b00;
                        r_dwell <= '0;
                    end
                end
                S_HOLD1: begin
                    if (r_dwell != c_DWELL_LAST) begin
                        r_dwell <= r_dwell + DWELL_W'(1);
                    end else if (req[0]) begin
                        r_state <= S_HOLD0;
                        r_gnt   <= 2'b01;
                        r_dwell <= '0;
                        r_rr    <= 1'b1;
                    end else if (req[1]) begin
                        r_dwell <= '0;
                        r_rr    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_gnt   <= 2'b00;
                        r_dwell <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                    r_dwell <= '0;
                end
            endcase
        end
    end

    // Free-running scan counter; its top two bits select the active digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + REFRESH_BITS'(1);
        end
    end

    assign w_digit = r_scan[REFRESH_BITS-1 -: 2];

    // Live source mux: the granted source's value and decimal points
    always_comb begin
        w_val = val0;
        w_dp  = dp0;
        if (r_state == S_HOLD1) begin
            w_val = val1;
            w_dp  = dp1;
        end
    end

    // Nibble select and leading-zero detection for the active digit
    always_comb begin
        w_nibble  = w_val[3:0];
        w_lz_zero = 1'b0;
        case (w_digit)
            2'd0: begin
                w_nibble  = w_val[3:0];
                w_lz_zero = 1'b0;
            end
            2'd1: begin
                w_nibble  = w_val[7:4];
                w_lz_zero = (w_val[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble  = w_val[11:8];
                w_lz_zero = (w_val[15:8] == 8'h00);
            end
            default: begin
                w_nibble  = w_val[15:12];
                w_lz_zero = (w_val[15:12] == 4'h0);
            end
        endcase
    end

    // Hex to active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_hex = 7'b1111111;
        case (w_nibble)
            4'h0: w_hex = 7'b1000000;
            4'h1: w_hex = 7'b1111001;
            4'h2: w_hex = 7'b0100100;
            4'h3: w_hex = 7'b0110000;
            4'h4: w_hex = 7'b0011001;
            4'h5: w_hex = 7'b0010010;
            4'h6: w_hex = 7'b0000010;
            4'h7: w_hex = 7'b1111000;
            4'h8: w_hex = 7'b0000000;
            4'h9: w_hex = 7'b0010000;
            4'hA: w_hex = 7'b0001000;
            4'hB: w_hex = 7'b0000011;
            4'hC: w_hex = 7'b1000110;
            4'hD: w_hex = 7'b0100001;
            4'hE: w_hex = 7'b0000110;
            default: w_hex = 7'b0001110;
        endcase
    end

    assign w_blank     = (r_state == S_IDLE) || (blank_lz && w_lz_zero);
    assign w_an_next   = w_blank ? 4'b1111 : ~(4'b0001 << w_digit);
    assign w_sseg_next = w_blank ? 8'hFF : {~w_dp[w_digit], w_hex};

    // Registered display drive, one cycle behind grant/digit/value changes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an   <= 4'b1111;
            r_sseg <= 8'hFF;
        end else begin
            r_an   <= w_an_next;
            r_sseg <= w_sseg_next;
        end
    end

    assign gnt  = r_gnt;
    assign an   = r_an;
    assign sseg = r_sseg;

endmodule
`default_nettype wire
